// File: rtl/ram2raccoon.sv
// Ring-bus master port: turns a local REQ/ACK memory request into a request
// word on the ring, then waits for the matching response (or for the request
// to come back unclaimed, or for a timeout) and reports completion.
// Ring word layout:
//   [79] valid  [78] write  [77:76] type (00 request, 10 response)
//   [75:69] initiator ID  [68] sequence bit  [67:64] mask
//   [63:32] data  [31:0] address
module ram2raccoon #(
  parameter logic [6:0]  MASTER_ID = 7'h01,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [79:0] RaccIn,
  output logic [79:0] RaccOut,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [3:0]  MASK,
  input  logic [31:0] WR_DATA,
  output logic [31:0] RD_DATA,
  output logic        ACK,
  output logic        ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_REQ  = 2'b00;
  localparam logic [1:0] TYPE_RESP = 2'b10;

  state_t      state_q, state_d;
  logic [79:0] din_q;
  logic [79:0] racc_out_q, racc_out_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        seq_q, seq_d;     // sequence bit the next request will carry
  logic [15:0] cnt_q, cnt_d;

  logic own_word;
  logic seq_is_outstanding;
  logic hit;
  logic stale;
  logic timeout_hit;

  // A word belongs to us when it is valid and carries our initiator ID.
  // While waiting, the outstanding request carries the inverse of seq_q
  // (seq toggles on issue); any other seq value of ours is left over from an
  // aborted transaction. Outside WAIT nothing is outstanding, so an own word
  // with the previously used seq value is stale.
  always_comb begin
    own_word           = din_q[79] && (din_q[75:69] == MASTER_ID);
    seq_is_outstanding = (din_q[68] == ~seq_q);
    hit                = own_word && (state_q == WAIT) && seq_is_outstanding;
    stale              = own_word && ((state_q == WAIT) ? (din_q[68] == seq_q)
                                                        : (din_q[68] != seq_q));
    timeout_hit        = (cnt_q == (TIMEOUT - 16'd1));
  end

  // Next-state and datapath decisions; default is plain pass-through.
  always_comb begin
    state_d    = state_q;
    racc_out_d = din_q;
    rd_data_d  = rd_data_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    seq_d      = seq_q;
    cnt_d      = cnt_q;

    if (stale) begin
      racc_out_d = 80'd0;
    end

    case (state_q)
      IDLE: begin
        // REQ is still high during the ACK cycle; do not start a new request.
        if (REQ && !ack_q) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Only an empty slot may carry our request; occupied slots pass on.
        if (!din_q[79]) begin
          racc_out_d = {1'b1, WE, TYPE_REQ, MASTER_ID, seq_q, MASK, WR_DATA, ADDR};
          seq_d      = ~seq_q;
          cnt_d      = 16'd0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
        // A matching response beats a simultaneous timeout.
        if (hit && (din_q[77:76] == TYPE_RESP)) begin
          racc_out_d = 80'd0;
          rd_data_d  = din_q[63:32];
          ack_d      = 1'b1;
          state_d    = IDLE;
        end else if (hit && (din_q[77:76] == TYPE_REQ)) begin
          // Went all the way round without any target claiming it.
          racc_out_d = 80'd0;
          rd_data_d  = 32'd0;
          ack_d      = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          // seq stays toggled so a late response is discarded as stale.
          rd_data_d = 32'd0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Input capture register and all state/output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      din_q      <= 80'd0;
      racc_out_q <= 80'd0;
      rd_data_q  <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      seq_q      <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      din_q      <= RaccIn;
      racc_out_q <= racc_out_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RaccOut = racc_out_q;
  assign RD_DATA = rd_data_q;
  assign ACK     = ack_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ram2raccoon.sv
// Directed table-driven bench for ram2raccoon (MASTER_ID=01, TIMEOUT=8).
// Each table row is one clock: inputs applied, then outputs compared just
// after the rising edge.
module tb_ram2raccoon;

  logic        CLK = 1'b0;
  logic        RST;
  logic [79:0] RaccIn;
  logic [79:0] RaccOut;
  logic        REQ;
  logic        WE;
  logic [31:0] ADDR;
  logic [3:0]  MASK;
  logic [31:0] WR_DATA;
  logic [31:0] RD_DATA;
  logic        ACK;
  logic        ERR;

  always #5 CLK = ~CLK;

  ram2raccoon #(
    .MASTER_ID(7'h01),
    .TIMEOUT  (16'd8)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RaccIn (RaccIn),
    .RaccOut(RaccOut),
    .REQ    (REQ),
    .WE     (WE),
    .ADDR   (ADDR),
    .MASK   (MASK),
    .WR_DATA(WR_DATA),
    .RD_DATA(RD_DATA),
    .ACK    (ACK),
    .ERR    (ERR)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [79:0] rin;
    logic [79:0] e_out;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        tbl[$];
  int          n_pass  = 0;
  int          n_total = 0;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [3:0]  cur_mask;
  logic [31:0] cur_wd;

  function automatic logic [79:0] mk(input logic v, input logic w, input logic [1:0] t,
                                     input logic [6:0] id, input logic s, input logic [3:0] m,
                                     input logic [31:0] d, input logic [31:0] a);
    return {v, w, t, id, s, m, d, a};
  endfunction

  // Foreign traffic (initiator 02) for the pass-through run.
  function automatic logic [79:0] oth(input int k);
    return mk(1'b1, 1'b0, 2'b00, 7'h02, 1'b0, 4'hF, 32'h1000 + k, 32'h2000 + k);
  endfunction

  task automatic add(input logic req, input logic [79:0] rin, input logic [79:0] e_out,
                     input logic e_ack, input logic e_err, input logic [31:0] e_rd);
    vec_t v;
    v.req   = req;
    v.we    = cur_we;
    v.addr  = cur_addr;
    v.mask  = cur_mask;
    v.wd    = cur_wd;
    v.rin   = rin;
    v.e_out = e_out;
    v.e_ack = e_ack;
    v.e_err = e_err;
    v.e_rd  = e_rd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [79:0] e_out, input logic e_ack,
                         input logic e_err, input logic [31:0] e_rd);
    chk({tag, " RaccOut"}, RaccOut, e_out);
    chk({tag, " ACK"}, {79'd0, ACK}, {79'd0, e_ack});
    chk({tag, " ERR"}, {79'd0, ERR}, {79'd0, e_err});
    chk({tag, " RD_DATA"}, {48'd0, RD_DATA}, {48'd0, e_rd});
  endtask

  logic [79:0] resp0, r1, r2, r3, oth_w, stale_w, resp3, late_w;

  initial begin
    // ---------------- build the vector table ----------------
    resp0   = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b0, 4'hF, 32'hDEADBEEF, 32'h00010004);
    r1      = mk(1'b1, 1'b1, 2'b00, 7'h01, 1'b1, 4'h3, 32'h12345678, 32'h00000100);
    r3      = mk(1'b1, 1'b0, 2'b00, 7'h01, 1'b0, 4'hC, 32'h0, 32'h00000200);
    oth_w   = mk(1'b1, 1'b1, 2'b00, 7'h02, 1'b1, 4'h5, 32'hAAAA5555, 32'h00000300);
    stale_w = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b1, 4'hF, 32'hBAD0BAD0, 32'h00000200);
    resp3   = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b0, 4'hC, 32'h5A5AA5A5, 32'h00000200);
    r2      = mk(1'b1, 1'b0, 2'b00, 7'h01, 1'b1, 4'hF, 32'h0, 32'h00000040);
    late_w  = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b1, 4'hF, 32'hCAFEF00D, 32'h00000040);

    // A: busy ring of foreign words, then read issue and response.
    cur_we = 1'b0; cur_addr = 32'h00010004; cur_mask = 4'hF; cur_wd = 32'h0;
    for (int k = 0; k < 20; k++)
      add(1'b1, oth(k), (k == 0) ? 80'd0 : oth(k - 1), 1'b0, 1'b0, 32'h0);
    add(1'b1, 80'd0, oth(19), 1'b0, 1'b0, 32'h0);
    add(1'b1, 80'd0, mk(1'b1, 1'b0, 2'b00, 7'h01, 1'b0, 4'hF, 32'h0, 32'h00010004),
        1'b0, 1'b0, 32'h0);
    add(1'b1, resp0, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 80'd0, 80'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    add(1'b0, 80'd0, 80'd0, 1'b0, 1'b0, 32'hDEADBEEF);

    // B: write request comes back unclaimed (seq 1).
    cur_we = 1'b1; cur_addr = 32'h00000100; cur_mask = 4'h3; cur_wd = 32'h12345678;
    add(1'b1, 80'd0, 80'd0, 1'b0, 1'b0, 32'hDEADBEEF);
    add(1'b1, 80'd0, r1, 1'b0, 1'b0, 32'hDEADBEEF);
    add(1'b1, r1, 80'd0, 1'b0, 1'b0, 32'hDEADBEEF);
    add(1'b1, 80'd0, 80'd0, 1'b1, 1'b1, 32'h0);
    add(1'b0, 80'd0, 80'd0, 1'b0, 1'b0, 32'h0);

    // D: foreign word untouched, stale own word removed, response ties timeout.
    cur_we = 1'b0; cur_addr = 32'h00000200; cur_mask = 4'hC; cur_wd = 32'h0;
    add(1'b1, 80'd0, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 80'd0, r3, 1'b0, 1'b0, 32'h0);
    add(1'b1, oth_w, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b1, stale_w, oth_w, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      add(1'b1, 80'd0, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b1, resp3, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 80'd0, 80'd0, 1'b1, 1'b0, 32'h5A5AA5A5);
    add(1'b0, 80'd0, 80'd0, 1'b0, 1'b0, 32'h5A5AA5A5);

    // C: no response -> timeout 8 cycles after issue, late response removed.
    cur_we = 1'b0; cur_addr = 32'h00000040; cur_mask = 4'hF; cur_wd = 32'h0;
    add(1'b1, 80'd0, 80'd0, 1'b0, 1'b0, 32'h5A5AA5A5);
    add(1'b1, 80'd0, r2, 1'b0, 1'b0, 32'h5A5AA5A5);
    for (int k = 0; k < 7; k++)
      add(1'b1, 80'd0, 80'd0, 1'b0, 1'b0, 32'h5A5AA5A5);
    add(1'b1, 80'd0, 80'd0, 1'b1, 1'b1, 32'h0);
    add(1'b0, late_w, 80'd0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 80'd0, 80'd0, 1'b0, 1'b0, 32'h0);

    // ---------------- reset ----------------
    RST = 1'b1; RaccIn = 80'd0; REQ = 1'b0; WE = 1'b0;
    ADDR = 32'h0; MASK = 4'h0; WR_DATA = 32'h0;
    step();
    step();
    chk_all("reset", 80'd0, 1'b0, 1'b0, 32'h0);
    RST = 1'b0;

    // ---------------- table run ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      REQ     = tbl[i].req;
      WE      = tbl[i].we;
      ADDR    = tbl[i].addr;
      MASK    = tbl[i].mask;
      WR_DATA = tbl[i].wd;
      RaccIn  = tbl[i].rin;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].e_out, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_rd);
    end

    // ---------------- reset in WAIT ----------------
    REQ = 1'b1; WE = 1'b0; ADDR = 32'h00000500; MASK = 4'hF; WR_DATA = 32'h0;
    RaccIn = 80'd0;
    step();
    step();
    chk("rst issue seq0", RaccOut, mk(1'b1, 1'b0, 2'b00, 7'h01, 1'b0, 4'hF, 32'h0, 32'h500));
    RaccIn = oth(0);
    step();
    RaccIn = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b0, 4'hF, 32'h11112222, 32'h500);
    step();
    chk("rst pre RaccOut", RaccOut, oth(0));
    #2;
    RST = 1'b1;
    #1;
    chk_all("rst async", 80'd0, 1'b0, 1'b0, 32'h0);
    RaccIn = 80'd0; REQ = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_all($sformatf("rst hold%0d", k), 80'd0, 1'b0, 1'b0, 32'h0);
    end
    RST = 1'b0;
    RaccIn = mk(1'b1, 1'b0, 2'b10, 7'h01, 1'b1, 4'hF, 32'h33334444, 32'h500);
    step();
    chk_all("post rst a", 80'd0, 1'b0, 1'b0, 32'h0);
    RaccIn = 80'd0; REQ = 1'b1;
    step();
    chk_all("post rst stale", 80'd0, 1'b0, 1'b0, 32'h0);
    step();
    chk("post rst issue", RaccOut, mk(1'b1, 1'b0, 2'b00, 7'h01, 1'b0, 4'hF, 32'h0, 32'h500));
    REQ = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
